// File: rtl/ddr_frame_arbiter.sv
// ddr_frame_arbiter: round-robin DDR3 burst arbiter between camera writes and display reads,
// owning frame-bank rotation. Define TRIPLE_BUF_EN for three-bank (tear-free) buffering.
//
// state | meaning
// IDLE  | apply pending frame starts, then arbitrate between eligible requests
// CMD   | cmd_valid high, command held until cmd_ready
// WAIT  | burst accepted, waiting for burst_done
module ddr_frame_arbiter #(
    parameter int                ADDR_W       = 28,
    parameter int                BURST_LEN    = 64,
    parameter int                FRAME_BURSTS = 900,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(32'h0020_0000),
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'h0000_0000)
) (
    input  logic              phy_clk,
    input  logic              phy_rst,
    input  logic              init_calib_complete,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              vin_frame_start,
    input  logic              vout_frame_start,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              burst_done,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic              frame_write_done,
    output logic              frame_read_done
);

    localparam int                CNT_W       = $clog2(FRAME_BURSTS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(FRAME_BURSTS);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 32);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT
    } state_t;

    state_t            state, state_d;
    logic              cmd_valid_d, cmd_wr_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic              last_wr, last_wr_d;
    logic [CNT_W-1:0]  wr_cnt, wr_cnt_d, rd_cnt, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_inc, rd_cnt_inc, sel_cnt;
    logic [1:0]        wr_bank_d, rd_bank_d, done_bank, done_bank_d, sel_bank;
    logic              vin_pend, vin_pend_d, vout_pend, vout_pend_d;
    logic              write_done_d, read_done_d;
    logic              wr_elig, rd_elig, grant_wr;

    always_ff @(posedge phy_clk) begin
        if (phy_rst) begin
            state            <= S_IDLE;
            cmd_valid        <= 1'b0;
            cmd_wr           <= 1'b0;
            cmd_addr         <= '0;
            last_wr          <= 1'b0;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            wr_bank          <= 2'd0;
            rd_bank          <= 2'd1;
            done_bank        <= 2'd1;
            vin_pend         <= 1'b0;
            vout_pend        <= 1'b0;
            frame_write_done <= 1'b0;
            frame_read_done  <= 1'b0;
        end else begin
            state            <= state_d;
            cmd_valid        <= cmd_valid_d;
            cmd_wr           <= cmd_wr_d;
            cmd_addr         <= cmd_addr_d;
            last_wr          <= last_wr_d;
            wr_cnt           <= wr_cnt_d;
            rd_cnt           <= rd_cnt_d;
            wr_bank          <= wr_bank_d;
            rd_bank          <= rd_bank_d;
            done_bank        <= done_bank_d;
            vin_pend         <= vin_pend_d;
            vout_pend        <= vout_pend_d;
            frame_write_done <= write_done_d;
            frame_read_done  <= read_done_d;
        end
    end

    always_comb begin
        state_d      = state;
        cmd_valid_d  = cmd_valid;
        cmd_wr_d     = cmd_wr;
        cmd_addr_d   = cmd_addr;
        last_wr_d    = last_wr;
        wr_cnt_d     = wr_cnt;
        rd_cnt_d     = rd_cnt;
        wr_bank_d    = wr_bank;
        rd_bank_d    = rd_bank;
        done_bank_d  = done_bank;
        vin_pend_d   = vin_pend | vin_frame_start;
        vout_pend_d  = vout_pend | vout_frame_start;
        write_done_d = 1'b0;
        read_done_d  = 1'b0;
        wr_elig      = 1'b0;
        rd_elig      = 1'b0;
        grant_wr     = 1'b0;
        sel_bank     = 2'd0;
        sel_cnt      = '0;
        wr_cnt_inc   = wr_cnt + CNT_W'(1);
        rd_cnt_inc   = rd_cnt + CNT_W'(1);

        unique case (state)
            S_IDLE: begin
                // Frame starts land before arbitration so this cycle's grant sees them;
                // a pulse coinciding with consumption stays pending for the next IDLE cycle.
                if (vout_pend) begin
                    rd_bank_d   = done_bank;
                    rd_cnt_d    = '0;
                    vout_pend_d = vout_frame_start;
                end
                if (vin_pend) begin
                    if (wr_cnt == CNT_MAX) begin
`ifdef TRIPLE_BUF_EN
                        if (rd_bank_d != 2'd0 && done_bank != 2'd0)
                            wr_bank_d = 2'd0;
                        else if (rd_bank_d != 2'd1 && done_bank != 2'd1)
                            wr_bank_d = 2'd1;
                        else
                            wr_bank_d = 2'd2;
`else
                        wr_bank_d = {1'b0, ~wr_bank[0]};
`endif
                    end
                    wr_cnt_d   = '0;
                    vin_pend_d = vin_frame_start;
                end

                wr_elig  = wr_req && (wr_cnt_d < CNT_MAX);
                rd_elig  = rd_req && (rd_cnt_d < CNT_MAX);
                grant_wr = wr_elig && (!rd_elig || !last_wr);
                sel_bank = grant_wr ? wr_bank_d : rd_bank_d;
                sel_cnt  = grant_wr ? wr_cnt_d : rd_cnt_d;

                if (init_calib_complete && (wr_elig || rd_elig)) begin
                    state_d     = S_CMD;
                    cmd_valid_d = 1'b1;
                    cmd_wr_d    = grant_wr;
                    last_wr_d   = grant_wr;
                    cmd_addr_d  = BASE_ADDR + ADDR_W'(sel_bank) * FRAME_STRIDE
                                  + ADDR_W'(sel_cnt) * BURST_BYTES;
                end
            end

            S_CMD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end

            S_WAIT: begin
                if (burst_done) begin
                    state_d = S_IDLE;
                    if (cmd_wr) begin
                        wr_cnt_d = wr_cnt_inc;
                        if (wr_cnt_inc == CNT_MAX) begin
                            write_done_d = 1'b1;
                            done_bank_d  = wr_bank;
                        end
                    end else begin
                        rd_cnt_d = rd_cnt_inc;
                        if (rd_cnt_inc == CNT_MAX)
                            read_done_d = 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Self-checking bench for ddr_frame_arbiter: directed scenarios plus randomized traffic
// checked against a frame-level reference model of banks, counters and round-robin order.
module tb_ddr_frame_arbiter;

    localparam int          FB        = 900;
    localparam int          BURST_LEN = 64;
    localparam logic [31:0] STRIDE    = 32'h0020_0000;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    logic        phy_clk = 1'b0;
    logic        phy_rst, init_calib_complete, wr_req, rd_req;
    logic        vin_frame_start, vout_frame_start, cmd_ready, burst_done;
    logic        cmd_valid, cmd_wr, frame_write_done, frame_read_done;
    logic [27:0] cmd_addr;
    logic [1:0]  wr_bank, rd_bank;

    int checks = 0;
    int errors = 0;

    int m_wr_cnt, m_rd_cnt, m_wr_bank, m_rd_bank, m_done_bank;
    bit m_last_wr, m_vin_pend, m_vout_pend;

    always #5 phy_clk = ~phy_clk;

    ddr_frame_arbiter dut (
        .phy_clk            (phy_clk),
        .phy_rst            (phy_rst),
        .init_calib_complete(init_calib_complete),
        .wr_req             (wr_req),
        .rd_req             (rd_req),
        .vin_frame_start    (vin_frame_start),
        .vout_frame_start   (vout_frame_start),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_wr             (cmd_wr),
        .cmd_addr           (cmd_addr),
        .burst_done         (burst_done),
        .wr_bank            (wr_bank),
        .rd_bank            (rd_bank),
        .frame_write_done   (frame_write_done),
        .frame_read_done    (frame_read_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr_cnt    = 0;
        m_rd_cnt    = 0;
        m_wr_bank   = 0;
        m_rd_bank   = 1;
        m_done_bank = 1;
        m_last_wr   = 1'b0;
        m_vin_pend  = 1'b0;
        m_vout_pend = 1'b0;
    endtask

    function automatic int advance_bank();
`ifdef TRIPLE_BUF_EN
        for (int b = 0; b < 3; b++)
            if (b != m_rd_bank && b != m_done_bank) return b;
        return 0;
`else
        return 1 - m_wr_bank;
`endif
    endfunction

    // Frame starts observed since the last arbitration take effect before the next one.
    task automatic model_apply();
        if (m_vout_pend) begin
            m_rd_bank   = m_done_bank;
            m_rd_cnt    = 0;
            m_vout_pend = 1'b0;
        end
        if (m_vin_pend) begin
            if (m_wr_cnt == FB) m_wr_bank = advance_bank();
            m_wr_cnt   = 0;
            m_vin_pend = 1'b0;
        end
    endtask

    function automatic logic [31:0] addr_of(input int bank, input int cnt);
        return BASE + 32'(bank) * STRIDE + 32'(cnt) * 32'(BURST_LEN * 32);
    endfunction

    // One arbitration round; entered and left on a negedge with the DUT idle.
    task automatic step(input bit wq, input bit rq, input int rdy_dly, input int done_dly,
                        input bit pv_in, input bit pv_out);
        bit          wel, rel, exp_wr, exp_fwd, exp_frd;
        logic [31:0] exp_addr;
        int          n;
        wr_req = wq;
        rd_req = rq;
        model_apply();
        wel = wq && (m_wr_cnt < FB);
        rel = rq && (m_rd_cnt < FB);
        if (!wel && !rel) begin
            repeat (6) @(negedge phy_clk);
            check("idle_no_cmd", 32'(cmd_valid), 32'd0);
            wr_req           = 1'b0;
            rd_req           = 1'b0;
            vin_frame_start  = pv_in;
            vout_frame_start = pv_out;
            @(negedge phy_clk);
            vin_frame_start  = 1'b0;
            vout_frame_start = 1'b0;
            if (pv_in) m_vin_pend = 1'b1;
            if (pv_out) m_vout_pend = 1'b1;
            repeat (2) @(negedge phy_clk);
            return;
        end
        exp_wr    = wel && (!rel || !m_last_wr);
        exp_addr  = exp_wr ? addr_of(m_wr_bank, m_wr_cnt) : addr_of(m_rd_bank, m_rd_cnt);
        m_last_wr = exp_wr;

        n = 0;
        do begin
            @(negedge phy_clk);
            n++;
        end while (!cmd_valid && n < 20);
        check("cmd_latency", 32'(n), 32'd1);
        if (!cmd_valid) return;
        check("cmd_wr", 32'(cmd_wr), 32'(exp_wr));
        check("cmd_addr", 32'(cmd_addr), exp_addr);
        check("wr_bank", 32'(wr_bank), 32'(m_wr_bank));
        check("rd_bank", 32'(rd_bank), 32'(m_rd_bank));

        // Stall the handshake; a stray burst_done here must be ignored.
        for (int i = 0; i < rdy_dly; i++) begin
            burst_done = (i == 0);
            @(negedge phy_clk);
            check("hold_valid", 32'(cmd_valid), 32'd1);
            check("hold_wr", 32'(cmd_wr), 32'(exp_wr));
            check("hold_addr", 32'(cmd_addr), exp_addr);
        end
        burst_done = 1'b0;
        cmd_ready  = 1'b1;
        @(negedge phy_clk);
        cmd_ready = 1'b0;
        check("valid_drop", 32'(cmd_valid), 32'd0);

        vin_frame_start  = pv_in;
        vout_frame_start = pv_out;
        @(negedge phy_clk);
        vin_frame_start  = 1'b0;
        vout_frame_start = 1'b0;
        if (pv_in) m_vin_pend = 1'b1;
        if (pv_out) m_vout_pend = 1'b1;
        check("wait_wr_bank", 32'(wr_bank), 32'(m_wr_bank));
        check("wait_rd_bank", 32'(rd_bank), 32'(m_rd_bank));
        repeat (done_dly) @(negedge phy_clk);

        burst_done = 1'b1;
        exp_fwd    = 1'b0;
        exp_frd    = 1'b0;
        if (exp_wr) begin
            m_wr_cnt++;
            if (m_wr_cnt == FB) begin
                exp_fwd     = 1'b1;
                m_done_bank = m_wr_bank;
            end
        end else begin
            m_rd_cnt++;
            if (m_rd_cnt == FB) exp_frd = 1'b1;
        end
        @(negedge phy_clk);
        burst_done = 1'b0;
        check("frame_write_done", 32'(frame_write_done), 32'(exp_fwd));
        check("frame_read_done", 32'(frame_read_done), 32'(exp_frd));
    endtask

    initial begin
        phy_rst             = 1'b1;
        init_calib_complete = 1'b0;
        wr_req              = 1'b0;
        rd_req              = 1'b0;
        vin_frame_start     = 1'b0;
        vout_frame_start    = 1'b0;
        cmd_ready           = 1'b0;
        burst_done          = 1'b0;
        model_reset();
        repeat (3) @(negedge phy_clk);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_wr", 32'(cmd_wr), 32'd0);
        check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        check("rst_wr_bank", 32'(wr_bank), 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd1);
        check("rst_fwd", 32'(frame_write_done), 32'd0);
        check("rst_frd", 32'(frame_read_done), 32'd0);
        phy_rst = 1'b0;

        // Calibration pending: requests and a frame start, but no command.
        wr_req          = 1'b1;
        rd_req          = 1'b1;
        vin_frame_start = 1'b1;
        @(negedge phy_clk);
        vin_frame_start = 1'b0;
        m_vin_pend      = 1'b1;
        repeat (8) @(negedge phy_clk);
        check("calib_low_no_cmd", 32'(cmd_valid), 32'd0);
        wr_req              = 1'b0;
        rd_req              = 1'b0;
        init_calib_complete = 1'b1;
        @(negedge phy_clk);

        // Plain write stream: 0x0, 0x800, 0x1000.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 3, 1'b0, 1'b0);

        // Both requesting: strict alternation.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 0, 3, 1'b0, 1'b0);

        // Finish the write frame, confirm writes stop, then rotate.
        while (m_wr_cnt < FB)
            step(1'b1, 1'b0, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 0, 3, 1'b0, 1'b0);
`ifdef TRIPLE_BUF_EN
        check("wr_bank_advanced", 32'(wr_bank), 32'd2);
`else
        check("wr_bank_advanced", 32'(wr_bank), 32'd1);
        check("frame2_first_addr", 32'(cmd_addr), 32'h0020_0000);
`endif

        // Incomplete frame (10 bursts) is discarded: same bank, counter restarts.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 0, 2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 0, 3, 1'b0, 1'b0);
`ifndef TRIPLE_BUF_EN
        check("discard_wr_bank", 32'(wr_bank), 32'd1);
        check("discard_addr", 32'(cmd_addr), 32'h0020_0000);
`endif

        // Display vsync during WAIT: switch lands only after burst_done.
        step(1'b0, 1'b1, 0, 3, 1'b0, 1'b1);
        step(1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
        check("rd_bank_from_done", 32'(rd_bank), 32'd0);

        // Long stall with cmd_ready low.
        step(1'b1, 1'b0, 20, 3, 1'b0, 1'b0);

        // Complete a read frame; reads then stop.
        while (m_rd_cnt < FB)
            step(1'b0, 1'b1, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 1'b0);
        step(1'b0, 1'b1, 0, 3, 1'b0, 1'b0);

        // Randomized traffic and frame starts.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);

        // Reset while a command is outstanding.
        wr_req = 1'b1;
        rd_req = 1'b1;
        @(negedge phy_clk);
        check("pre_reset_valid", 32'(cmd_valid), 32'd1);
        phy_rst = 1'b1;
        @(negedge phy_clk);
        check("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("midrst_cmd_addr", 32'(cmd_addr), 32'd0);
        check("midrst_wr_bank", 32'(wr_bank), 32'd0);
        check("midrst_rd_bank", 32'(rd_bank), 32'd1);
        phy_rst = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        model_reset();
        @(negedge phy_clk);
        step(1'b1, 1'b0, 0, 3, 1'b0, 1'b0);
        check("post_reset_addr", 32'(cmd_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
